// File: rtl/mem_arbiter_if.sv
// Bundle of both requester ports and the single-port data-memory bus seen by mem_arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters' and memory's view.
interface mem_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 12
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          lock0;
  logic          gnt0;
  logic          rvalid0;
  logic [DW-1:0] rdata0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          lock1;
  logic          gnt1;
  logic          rvalid1;
  logic [DW-1:0] rdata1;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0, lock0,
    input  req1, we1, addr1, wdata1, lock1,
    input  mem_rdata,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, we0, addr0, wdata0, lock0,
    output req1, we1, addr1, wdata1, lock1,
    output mem_rdata,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter with lock for a single-port synchronous memory (2-cycle read latency).
// Define MEM_ARB_FIXED_PRIO_EN to make port 0 win every idle tie instead of round-robin.
module mem_arbiter #(
  parameter int DW       = 32,
  parameter int AW       = 12,
  parameter int MAX_LOCK = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  arb_if
);
  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LOCK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          ptr_q, ptr_d;        // last-served port
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc_s;
  logic          gnt0_s, gnt1_s, gnt_any_s;
  logic          we_s;
  logic [AW-1:0] addr_s;
  logic [DW-1:0] wdata_s;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          rd_v_q, rd_id_q;
  logic          rvalid0_q, rvalid1_q;

  assign cnt_inc_s = cnt_q + CW'(1);
  assign gnt_any_s = gnt0_s | gnt1_s;
  assign we_s      = gnt1_s ? arb_if.we1    : arb_if.we0;
  assign addr_s    = gnt1_s ? arb_if.addr1  : arb_if.addr0;
  assign wdata_s   = gnt1_s ? arb_if.wdata1 : arb_if.wdata0;

  // Grant selection and ownership next state
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt0_s  = 1'b0;
    gnt1_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_if.req0 && arb_if.req1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
          gnt0_s = 1'b1;
`else
          gnt0_s = ptr_q;
          gnt1_s = ~ptr_q;
`endif
        end else begin
          gnt0_s = arb_if.req0;
          gnt1_s = arb_if.req1;
        end
        if (gnt0_s) begin
          ptr_d = 1'b0;
          if (arb_if.lock0) begin
            state_d = OWN0;
            cnt_d   = CW'(1);
          end else begin
            cnt_d   = '0;
          end
        end else if (gnt1_s) begin
          ptr_d = 1'b1;
          if (arb_if.lock1) begin
            state_d = OWN1;
            cnt_d   = CW'(1);
          end else begin
            cnt_d   = '0;
          end
        end else begin
          cnt_d = '0;
        end
      end
      OWN0: begin
        if (arb_if.req0) begin
          gnt0_s = 1'b1;
          ptr_d  = 1'b0;
          // The capping grant still issues; only the ownership is dropped.
          if (!arb_if.lock0 || (cnt_inc_s == MAX_CNT)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_inc_s;
          end
        end else if (!arb_if.lock0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q;
        end
      end
      OWN1: begin
        if (arb_if.req1) begin
          gnt1_s = 1'b1;
          ptr_d  = 1'b1;
          if (!arb_if.lock1 || (cnt_inc_s == MAX_CNT)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_inc_s;
          end
        end else if (!arb_if.lock1) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Arbitration state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Memory command register; address and data hold when nothing is granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (gnt_any_s) begin
      mem_we_q    <= we_s;
      mem_addr_q  <= addr_s;
      mem_wdata_q <= wdata_s;
    end else begin
      mem_we_q    <= 1'b0;
    end
  end

  // Read-return tracker: tags each read with its issuing port for two cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v_q    <= 1'b0;
      rd_id_q   <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      rd_v_q    <= gnt_any_s & ~we_s;
      rd_id_q   <= gnt1_s;
      rvalid0_q <= rd_v_q & ~rd_id_q;
      rvalid1_q <= rd_v_q & rd_id_q;
    end
  end

  assign arb_if.gnt0      = gnt0_s;
  assign arb_if.gnt1      = gnt1_s;
  assign arb_if.rvalid0   = rvalid0_q;
  assign arb_if.rvalid1   = rvalid1_q;
  assign arb_if.rdata0    = arb_if.mem_rdata;
  assign arb_if.rdata1    = arb_if.mem_rdata;
  assign arb_if.mem_we    = mem_we_q;
  assign arb_if.mem_addr  = mem_addr_q;
  assign arb_if.mem_wdata = mem_wdata_q;
endmodule
